// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with valid/ready on both sides and an iterative
// 1-bit-per-cycle shifter; define ALU_EXEC_BARREL_SHIFT_EN for single-cycle shifts.
module alu_exec_stage #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_op,
   input  logic [2:0]      funct3,
   input  logic            is_branch,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            branch_taken,
   output logic            illegal_op
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_SLL  = 4'b0010;
   localparam logic [3:0] OP_SLT  = 4'b0011;
   localparam logic [3:0] OP_SLTU = 4'b0100;
   localparam logic [3:0] OP_XOR  = 4'b0101;
   localparam logic [3:0] OP_SRL  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_OR   = 4'b1000;
   localparam logic [3:0] OP_AND  = 4'b1001;
   localparam logic [3:0] OP_EQ   = 4'b1011;
   localparam logic [3:0] OP_GE   = 4'b1100;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state_q;
   logic              out_valid_q;
   logic [XLEN-1:0]   result_q;
   logic              taken_q;
   logic              illegal_q;

   logic [SHAMT_W-1:0] shamt;
   logic               is_shift;
   logic               start_shift;
   logic               accept;
   logic [XLEN-1:0]    nxt_result;
   logic               nxt_illegal;
   logic               nxt_taken;

   function automatic logic taken_f(input logic r0, input logic br, input logic [2:0] f3);
      return br & (r0 ^ (f3 == 3'b001));
   endfunction

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high. Upstream: in_ready is high in IDLE, low in SHIFT, and follows
   // out_ready in DONE. Downstream: out_valid stays high and result /
   // branch_taken / illegal_op stay frozen until out_ready is seen.
   always_comb begin
      in_ready = 1'b0;
      case (state_q)
         IDLE:    in_ready = 1'b1;
         DONE:    in_ready = out_ready;
         default: in_ready = 1'b0;
      endcase
   end

   assign accept   = in_valid & in_ready;
   assign shamt    = op_b[SHAMT_W-1:0];
   assign is_shift = (alu_op == OP_SLL) | (alu_op == OP_SRL) | (alu_op == OP_SRA);

`ifdef ALU_EXEC_BARREL_SHIFT_EN
   assign start_shift = 1'b0;
`else
   assign start_shift = is_shift & (shamt != '0);
`endif

   // Single-cycle result, computed straight from the upstream operands.
   always_comb begin
      nxt_result  = '0;
      nxt_illegal = 1'b0;
      case (alu_op)
         OP_ADD:  nxt_result = op_a + op_b;
         OP_SUB:  nxt_result = op_a - op_b;
         OP_SLT:  nxt_result = XLEN'($signed(op_a) < $signed(op_b));
         OP_SLTU: nxt_result = XLEN'(op_a < op_b);
         OP_XOR:  nxt_result = op_a ^ op_b;
         OP_OR:   nxt_result = op_a | op_b;
         OP_AND:  nxt_result = op_a & op_b;
         OP_EQ:   nxt_result = XLEN'(op_a == op_b);
         OP_GE: begin
            if (funct3[1]) nxt_result = XLEN'(op_a >= op_b);
            else           nxt_result = XLEN'($signed(op_a) >= $signed(op_b));
         end
`ifdef ALU_EXEC_BARREL_SHIFT_EN
         OP_SLL:  nxt_result = op_a << shamt;
         OP_SRL:  nxt_result = op_a >> shamt;
         OP_SRA:  nxt_result = XLEN'($signed(op_a) >>> shamt);
`else
         // Only used when shamt is zero; otherwise the iterative path runs.
         OP_SLL, OP_SRL, OP_SRA: nxt_result = op_a;
`endif
         default: begin
            nxt_result  = '0;
            nxt_illegal = 1'b1;
         end
      endcase
      nxt_taken = ~nxt_illegal & taken_f(nxt_result[0], is_branch, funct3);
   end

`ifndef ALU_EXEC_BARREL_SHIFT_EN
   logic [XLEN-1:0]    work_q;
   logic [SHAMT_W-1:0] count_q;
   logic [3:0]         op_q;
   logic [2:0]         f3_q;
   logic               br_q;
   logic [XLEN-1:0]    work_shifted;

   always_comb begin
      work_shifted = work_q;
      case (op_q)
         OP_SLL:  work_shifted = {work_q[XLEN-2:0], 1'b0};
         OP_SRL:  work_shifted = {1'b0, work_q[XLEN-1:1]};
         OP_SRA:  work_shifted = {work_q[XLEN-1], work_q[XLEN-1:1]};
         default: work_shifted = work_q;
      endcase
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         taken_q     <= 1'b0;
         illegal_q   <= 1'b0;
`ifndef ALU_EXEC_BARREL_SHIFT_EN
         work_q      <= '0;
         count_q     <= '0;
         op_q        <= '0;
         f3_q        <= '0;
         br_q        <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (accept) begin
`ifndef ALU_EXEC_BARREL_SHIFT_EN
                  work_q  <= op_a;
                  count_q <= shamt;
                  op_q    <= alu_op;
                  f3_q    <= funct3;
                  br_q    <= is_branch;
`endif
                  if (start_shift) begin
                     state_q     <= SHIFT;
                     out_valid_q <= 1'b0;
                  end else begin
                     state_q     <= DONE;
                     out_valid_q <= 1'b1;
                     result_q    <= nxt_result;
                     taken_q     <= nxt_taken;
                     illegal_q   <= nxt_illegal;
                  end
               end else if (state_q == DONE && out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            SHIFT: begin
`ifndef ALU_EXEC_BARREL_SHIFT_EN
               // The last shift writes the result directly so DONE sees it.
               work_q <= work_shifted;
               if (count_q == SHAMT_W'(1)) begin
                  count_q     <= '0;
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
                  result_q    <= work_shifted;
                  taken_q     <= taken_f(work_shifted[0], br_q, f3_q);
                  illegal_q   <= 1'b0;
               end else begin
                  count_q <= count_q - SHAMT_W'(1);
               end
`else
               state_q <= IDLE;
`endif
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid    = out_valid_q;
   assign result       = result_q;
   assign branch_taken = taken_q;
   assign illegal_op   = illegal_q;

   a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |=> (out_valid && $stable(result) &&
                                     $stable(branch_taken) && $stable(illegal_op)));

   a_shift_not_ready: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == SHIFT) |-> !in_ready);

endmodule
